ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter for the piano's keyboard port. It sends one command byte to the keyboard, such as 0xED (set LEDs) or 0xFF (reset), and is the outbound counterpart of the existing PS/2 scan-code receiver. It runs in the 5 MHz domain and drives the shared ps2_clk/ps2_data lines through open-drain enables. The top level ties these enables to tristate pads, and the receiver is gated off while `busy` is high.

---
 rtl/ps2_host_tx_pkg.sv | 32 +++
 rtl/ps2_line_sync.sv | 35 +++
 rtl/ps2_host_tx.sv | 167 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_tx_pkg.sv
// rtl/ps2_host_tx_pkg.sv - shared states, error codes and command bytes for the PS/2 host link
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_WAIT1,
        ST_SHIFT,
        ST_ACK,
        ST_RECOV
    } ps2_tx_state_t;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_NOACK = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;

    localparam logic [7:0] PS2_CMD_LEDS  = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
    localparam logic [7:0] PS2_CMD_ECHO  = 8'hEE;

    localparam logic [3:0] EDGE_LAST = 4'd11;

    function automatic longint us_to_cyc(input longint freq_hz, input longint us);
        return freq_hz * us / 1000000;
    endfunction

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - two-flop synchronizers for the PS/2 lines plus clock falling-edge strobe
module ps2_line_sync (
    input  logic CLK,
    input  logic nCLR,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    logic clk_meta;
    logic data_meta;
    logic clk_hist;

    // Idle bus level is high, so reset to 1 to avoid a phantom edge after reset.
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_hist  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            clk_hist  <= clk_sync;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
        end
    end

    assign clk_fall = clk_hist & ~clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command byte transmitter with open-drain line enables
module ps2_host_tx #(
    parameter int CLK_FREQ     = 5000000,
    parameter int INHIBIT_US   = 120,
    parameter int START_TMO_US = 15000,
    parameter int FRAME_TMO_US = 2000
) (
    input  logic       CLK,
    input  logic       nCLR,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic [1:0] err
);
    import ps2_host_tx_pkg::*;

    localparam longint INHIBIT_CYC = us_to_cyc(CLK_FREQ, INHIBIT_US);
    localparam longint START_CYC   = us_to_cyc(CLK_FREQ, START_TMO_US);
    localparam longint FRAME_CYC   = us_to_cyc(CLK_FREQ, FRAME_TMO_US);
    localparam int     CNT_W       = $clog2(INHIBIT_CYC + START_CYC + FRAME_CYC);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST   = CNT_W'(FRAME_CYC - 1);

    ps2_tx_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       edge_cnt;
    logic [3:0]       edge_next;
    logic [8:0]       shreg;
    logic [1:0]       err_rec;
    logic             clk_sync;
    logic             data_sync;
    logic             clk_fall;
    logic             tmo;

    ps2_line_sync u_sync (
        .CLK         (CLK),
        .nCLR        (nCLR),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .clk_sync    (clk_sync),
        .data_sync   (data_sync),
        .clk_fall    (clk_fall)
    );

    assign edge_next = (edge_cnt == EDGE_LAST) ? edge_cnt : edge_cnt + 4'd1;

    // An edge landing on the final count still counts as on time.
    always_comb begin
        tmo = 1'b0;
        if (!clk_fall) begin
            if (state == ST_WAIT1)
                tmo = (cnt == START_LAST);
            else if (state == ST_SHIFT || state == ST_ACK)
                tmo = (cnt == FRAME_LAST);
        end
    end

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            edge_cnt    <= '0;
            shreg       <= '0;
            err_rec     <= ERR_OK;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= ERR_OK;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            done <= 1'b0;
            if (tmo) begin
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                done        <= 1'b1;
                err         <= ERR_TMO;
                busy        <= 1'b0;
                state       <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        tx_ready <= 1'b1;
                        if (tx_valid && tx_ready) begin
                            shreg      <= {odd_parity(tx_data), tx_data};
                            tx_ready   <= 1'b0;
                            busy       <= 1'b1;
                            ps2_clk_oe <= 1'b1;
                            cnt        <= '0;
                            edge_cnt   <= '0;
                            state      <= ST_INHIBIT;
                        end
                    end
                    ST_INHIBIT: begin
                        if (cnt == INHIBIT_LAST) begin
                            ps2_data_oe <= 1'b1;
                            state       <= ST_REQ;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_REQ: begin
                        ps2_clk_oe <= 1'b0;
                        cnt        <= '0;
                        state      <= ST_WAIT1;
                    end
                    ST_WAIT1: begin
                        if (clk_fall) begin
                            edge_cnt    <= 4'd1;
                            ps2_data_oe <= ~shreg[0];
                            shreg       <= {1'b0, shreg[8:1]};
                            cnt         <= '0;
                            state       <= ST_SHIFT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        cnt <= cnt + 1'b1;
                        if (clk_fall) begin
                            edge_cnt <= edge_next;
                            // Edges 2..9 carry data bits 1..7 and parity; edge 10 frees the line for stop.
                            if (edge_cnt == 4'd9) begin
                                ps2_data_oe <= 1'b0;
                                state       <= ST_ACK;
                            end else begin
                                ps2_data_oe <= ~shreg[0];
                                shreg       <= {1'b0, shreg[8:1]};
                            end
                        end
                    end
                    ST_ACK: begin
                        cnt <= cnt + 1'b1;
                        if (clk_fall) begin
                            edge_cnt <= edge_next;
                            err_rec  <= data_sync ? ERR_NOACK : ERR_OK;
                            state    <= ST_RECOV;
                        end
                    end
                    ST_RECOV: begin
                        if (clk_sync && data_sync) begin
                            done  <= 1'b1;
                            err   <= err_rec;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a wired-AND PS/2 device model
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    logic       clk = 1'b0;
    logic       nclr = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic [1:0] err;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_line;
    logic       ps2_data_line;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int wait1_cyc = 0;
    int d0;
    bit rdy_pend = 1'b0;

    logic [1:0]  err_q[$];
    logic [10:0] frame_q[$];

    assign ps2_clk_line  = ~ps2_clk_oe & ~dev_clk_low;
    assign ps2_data_line = ~ps2_data_oe & ~dev_data_low;

    ps2_host_tx dut (
        .CLK         (clk),
        .nCLR        (nclr),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected error code.
    always @(negedge clk) begin
        if (rdy_pend) begin
            chk("ready_after_done", {30'd0, busy, tx_ready}, 32'd1);
            rdy_pend = 1'b0;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            rdy_pend = 1'b1;
            chk("oe_at_done", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
            if (err_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done err=%0d exp=none", err);
            end else begin
                chk("done_err", {30'd0, err}, {30'd0, err_q.pop_front()});
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic par, input bit push_err,
                        input logic [1:0] e, input bit push_frame);
        int n = 0;
        int inh = 0;
        int req = 0;
        @(negedge clk);
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("tx_ready_before_send", {31'd0, tx_ready}, 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        if (push_err) err_q.push_back(e);
        if (push_frame) frame_q.push_back({1'b1, par, d, 1'b0});
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while (ps2_clk_oe && n < 2000) begin
            if (ps2_data_oe) req++;
            else inh++;
            @(negedge clk);
            n++;
        end
        wait1_cyc = cyc;
        chk("inhibit_cycles", inh, 32'd600);
        chk("req_cycles", req, 32'd1);
        chk("start_bit_held", {31'd0, ps2_data_oe}, 32'd1);
    endtask

    task automatic dev_run(input int half, input int n_edges, input bit ack, input bit chk_frame);
        logic [10:0] bits = '0;
        repeat (half) @(negedge clk);
        for (int k = 0; k < n_edges; k++) begin
            bits[k] = ps2_data_line;
            if (k == 10 && ack) begin
                dev_data_low = 1'b1;
                repeat (10) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (half) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (half) @(negedge clk);
        end
        dev_data_low = 1'b0;
        if (chk_frame) begin
            if (frame_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_bits got=%0h exp=none", bits);
            end else begin
                chk("frame_bits", {21'd0, bits}, {21'd0, frame_q.pop_front()});
            end
        end
    endtask

    task automatic wait_done(input int start_cnt, input int bound);
        int n = 0;
        while (done_cnt == start_cnt && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == start_cnt) begin
            checks++;
            errors++;
            $display("FAIL done_wait got=none exp=done");
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        nclr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {30'd0, err}, 32'd0);
        chk("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        nclr = 1'b1;
        repeat (5) @(negedge clk);

        // 0xED at a 400-cycle device clock, ACKed
        d0 = done_cnt;
        send(PS2_CMD_LEDS, 1'b1, 1'b1, ERR_OK, 1'b1);
        dev_run(200, 11, 1'b1, 1'b1);
        wait_done(d0, 2000);

        // 0x01 has odd weight, so parity bit is 0
        d0 = done_cnt;
        send(8'h01, 1'b0, 1'b1, ERR_OK, 1'b1);
        dev_run(40, 11, 1'b1, 1'b1);
        wait_done(d0, 2000);

        // silent device: start timeout
        d0 = done_cnt;
        send(8'h55, 1'b1, 1'b1, ERR_TMO, 1'b0);
        wait_done(d0, 80000);
        chk("start_timeout_cycles", done_cyc - wait1_cyc, 32'd75000);

        // no ACK on edge 11
        d0 = done_cnt;
        send(PS2_CMD_RESET, 1'b1, 1'b1, ERR_NOACK, 1'b1);
        dev_run(40, 11, 1'b0, 1'b1);
        wait_done(d0, 2000);

        // reset between edges 4 and 5
        send(PS2_CMD_RESET, 1'b1, 1'b0, ERR_OK, 1'b0);
        dev_run(40, 4, 1'b1, 1'b0);
        chk("busy_mid_frame", {31'd0, busy}, 32'd1);
        d0 = done_cnt;
        nclr = 1'b0;
        #1;
        chk("async_rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        chk("async_rst_busy_ready", {30'd0, busy, tx_ready}, 32'd1);
        repeat (5) @(negedge clk);
        chk("no_done_on_reset", done_cnt - d0, 32'd0);
        nclr = 1'b1;
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        send(8'h00, 1'b1, 1'b1, ERR_OK, 1'b1);
        dev_run(40, 11, 1'b1, 1'b1);
        wait_done(d0, 2000);

        // stray request during SHIFT must be ignored
        d0 = done_cnt;
        send(PS2_CMD_ECHO, 1'b1, 1'b1, ERR_OK, 1'b1);
        fork
            dev_run(40, 11, 1'b1, 1'b1);
            begin
                repeat (300) @(negedge clk);
                chk("busy_in_shift", {31'd0, busy}, 32'd1);
                tx_data  = 8'hAA;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        wait_done(d0, 2000);
        repeat (50) @(negedge clk);
        chk("single_done", done_cnt - d0, 32'd1);
        chk("queues_drained", err_q.size() + frame_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
